multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control-unit FSM for the multi-cycle ARM-subset core. It sequences the instruction-fetch stage by driving `write_ir`/`write_pc` and using the stage's condition-qualified `W_IR_valid`. It then decodes the latched `IR` and steps the datapath through decode, execute, memory and write-back, one state per clock. All datapath strobes are Moore outputs of a single state register.

## Interface
- `ST_W`, 4, state-register width (fixed encoding, see package)
- `clk`  in  1  clock; state register updates on rising edge (datapath/fetch capture on falling edge)
- `rst`  in  1  reset, asynchronous, active-high
- `run`  in  1  core enable; gates new fetches only
- `IR`  in  32  current instruction from the fetch stage
- `W_IR_valid`  in  1  fetch-stage flag: condition passed and IR written this cycle
- `write_ir`  out  1  request IR load
- `write_pc`  out  1  PC += 4
- `pc_load`  out  1  PC ← branch target
- `LA`, `LB`  out  1 each  latch register-file operands A and B
- `LC`  out  1  latch ALU result
- `LF`  out  1  latch NZCV from ALU
- `alu_op`  out  4  ALU opcode
- `src_imm`  out  1  ALU B-input selects the immediate
- `mem_write`  out  1  data-memory write strobe
- `LD`  out  1  latch memory read data
- `rf_write`  out  1  register-file write
- `wb_sel`  out  1  write-back source: 0 = ALU result C, 1 = load data
- `lr_write`  out  1  write PC to R14
- `illegal`  out  1  one-cycle pulse on an undefined class
- `state`  out  4  current state (debug)

## Operation
- Instruction fields:
  - `IR[27:26]` class: 00 data-proc, 01 load/store, 10 branch, 11 undefined.
  - `IR[25]` I bit; `IR[24:21]` opcode; `IR[20]` S (data-proc) or L (memory); `IR[23]` U; `IR[24]` link (branch).
- States and transitions:
  - FETCH: `write_ir`=`write_pc`=`run`.
    - Next is DECODE if `run` and `W_IR_valid`.
    - Otherwise stay in FETCH. A failed condition skips the instruction: PC advances, IR is held.
  - DECODE: `LA`=`LB`=1. Next by class:
    - 00 → EXEC_I if I=1, else EXEC_R.
    - 01 → MEM_ADDR.
    - 10 → BRANCH.
    - 11 → FETCH, with `illegal`=1.
  - EXEC_R / EXEC_I:
    - `alu_op`=`IR[24:21]`, `LC`=1, `LF`=S; `src_imm`=1 in EXEC_I.
    - Opcodes 1000–1011 (TST/TEQ/CMP/CMN) → FETCH, no write-back. Otherwise → WB.
  - WB: `rf_write`=1, `wb_sel`=0 → FETCH.
  - MEM_ADDR: `src_imm`=1, `LC`=1, `alu_op`=0100 (ADD) if U=1, else 0010 (SUB). Next is MEM_READ if L=1, else MEM_WRITE.
  - MEM_WRITE: `mem_write`=1 → FETCH.
  - MEM_READ: `LD`=1 → MEM_WB.
  - MEM_WB: `rf_write`=1, `wb_sel`=1 → FETCH.
  - BRANCH: `pc_load`=1, `lr_write`=`IR[24]` → FETCH.
- All unlisted outputs are 0 in each state. Unused state encodings → FETCH.
- `run` is sampled only in FETCH. Deasserting it mid-instruction lets the instruction complete.

## Timing
- Reset: state=FETCH. Outputs while `rst` is high: all 0, `alu_op`=0, `state`=0. `write_ir`/`write_pc` follow `run` once `rst` falls.
- Outputs change only after a rising edge, giving a half-cycle setup to the falling-edge capture in fetch and datapath.
- `W_IR_valid` is combinational from the fetch stage; it is sampled at the rising edge ending the FETCH cycle.
- Cycle counts, each including the fetch cycle:
  - compare: 3
  - data-proc with write-back: 4
  - STR: 4
  - LDR: 5
  - branch: 3
  - skipped instruction: 1
- `rst` mid-instruction aborts immediately. No strobe may glitch high during or after reset.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB=4, MEM_ADDR=5, MEM_READ=6, MEM_WB=7, MEM_WRITE=8, BRANCH=9
  - class codes
  - ALU opcode constants ADD=0100, SUB=0010, compare range 1000–1011
- Sub-module `ctrl_decode` (combinational), `IR` → `is_dp`, `is_mem`, `is_br`, `is_undef`, `is_cmp`, `imm`, `s_bit`, `load`, `up`, `link`. The FSM instantiates it once.

## Test plan
- ADD R1,R2,R3 (`IR`=0xE0821003, `W_IR_valid`=1) → states 0,1,2,4,0. `alu_op`=0100 in EXEC_R; `rf_write`=1 only in WB; `LF`=0.
- CMP R2,#5 (0xE3520005) → states 0,1,3,0. `src_imm`=1 and `LF`=1 in EXEC_I; `rf_write` never asserted.
- `W_IR_valid`=0 for 3 cycles with `run`=1 → stays in FETCH; `write_pc` high 3 cycles; no DECODE.
- LDR R2,[R1,#4] (0xE5912004) → states 0,1,5,6,7,0. `alu_op`=0100 in MEM_ADDR; `LD` in MEM_READ; `rf_write`+`wb_sel` in MEM_WB. STR (0xE5812004) → 0,1,5,8,0 with `mem_write`=1.
- BL (0xEB000002) → 0,1,9,0 with `pc_load`=`lr_write`=1. B (0xEA000002) → `lr_write`=0. Class 11 (0xEC000000) → `illegal` pulse, back to FETCH.
- `rst` asserted during MEM_READ → state 0 and all strobes 0 immediately. `run`=0 after reset release → FETCH held, `write_ir`=`write_pc`=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// classes and the ALU opcodes the controller drives itself.
package cpu_ctrl_pkg;

  localparam int unsigned ST_W   = 4;
  localparam int unsigned ALU_W  = 4;
  localparam int unsigned IR_W   = 32;
  localparam int unsigned CTL_W  = 8;   // IR[27:20], the bits the controller decodes

  typedef enum logic [ST_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_WB        = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    CLS_DP    = 2'b00,
    CLS_MEM   = 2'b01,
    CLS_BR    = 2'b10,
    CLS_UNDEF = 2'b11
  } cls_t;

  localparam logic [ALU_W-1:0] ALU_ADD    = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SUB    = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_CMP_LO = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_CMP_HI = 4'b1011;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational field decode of the latched instruction (IR[27:20]).
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [CTL_W-1:0] ir_ctl,
  output logic             is_dp,
  output logic             is_mem,
  output logic             is_br,
  output logic             is_undef,
  output logic             is_cmp,
  output logic             imm,
  output logic             s_bit,
  output logic             load,
  output logic             up,
  output logic             link
);

  logic [1:0]       cls;
  logic [ALU_W-1:0] opcode;

  assign cls    = ir_ctl[7:6];
  assign opcode = ir_ctl[4:1];

  assign is_dp    = (cls == CLS_DP);
  assign is_mem   = (cls == CLS_MEM);
  assign is_br    = (cls == CLS_BR);
  assign is_undef = (cls == CLS_UNDEF);

  // TST/TEQ/CMP/CMN only update flags, so they skip write-back
  assign is_cmp = (opcode >= ALU_CMP_LO) && (opcode <= ALU_CMP_HI);

  assign imm   = ir_ctl[5];
  assign s_bit = ir_ctl[0];
  assign load  = ir_ctl[0];
  assign up    = ir_ctl[3];
  assign link  = ir_ctl[4];

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: one state per clock, datapath
// strobes decoded from the state register (plus run/IR where needed).
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [IR_W-1:0]  IR,
  input  logic             W_IR_valid,
  output logic             write_ir,
  output logic             write_pc,
  output logic             pc_load,
  output logic             LA,
  output logic             LB,
  output logic             LC,
  output logic             LF,
  output logic [ALU_W-1:0] alu_op,
  output logic             src_imm,
  output logic             mem_write,
  output logic             LD,
  output logic             rf_write,
  output logic             wb_sel,
  output logic             lr_write,
  output logic             illegal,
  output logic [ST_W-1:0]  state
);

  state_t state_q, state_d;

  logic is_dp, is_mem, is_br, is_undef, is_cmp, imm, s_bit, load, up, link;
  logic unused_ir;

  assign unused_ir = ^{IR[31:28], IR[19:0]};

  ctrl_decode u_decode (
    .ir_ctl   (IR[27:20]),
    .is_dp    (is_dp),
    .is_mem   (is_mem),
    .is_br    (is_br),
    .is_undef (is_undef),
    .is_cmp   (is_cmp),
    .imm      (imm),
    .s_bit    (s_bit),
    .load     (load),
    .up       (up),
    .link     (link)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:     state_d = (run && W_IR_valid) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_dp)       state_d = imm ? S_EXEC_I : S_EXEC_R;
        else if (is_mem) state_d = S_MEM_ADDR;
        else if (is_br)  state_d = S_BRANCH;
        else             state_d = S_FETCH;
      end
      S_EXEC_R,
      S_EXEC_I:    state_d = is_cmp ? S_FETCH : S_WB;
      S_MEM_ADDR:  state_d = load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_MEM_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode; rst forces the fetch strobes low while the core is held
  always_comb begin
    write_ir  = 1'b0;
    write_pc  = 1'b0;
    pc_load   = 1'b0;
    LA        = 1'b0;
    LB        = 1'b0;
    LC        = 1'b0;
    LF        = 1'b0;
    alu_op    = '0;
    src_imm   = 1'b0;
    mem_write = 1'b0;
    LD        = 1'b0;
    rf_write  = 1'b0;
    wb_sel    = 1'b0;
    lr_write  = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        write_ir = run & ~rst;
        write_pc = run & ~rst;
      end
      S_DECODE: begin
        LA      = 1'b1;
        LB      = 1'b1;
        illegal = is_undef;
      end
      S_EXEC_R,
      S_EXEC_I: begin
        alu_op  = IR[24:21];
        LC      = 1'b1;
        LF      = s_bit;
        src_imm = (state_q == S_EXEC_I);
      end
      S_WB:        rf_write = 1'b1;
      S_MEM_ADDR: begin
        src_imm = 1'b1;
        LC      = 1'b1;
        alu_op  = up ? ALU_ADD : ALU_SUB;
      end
      S_MEM_WRITE: mem_write = 1'b1;
      S_MEM_READ:  LD = 1'b1;
      S_MEM_WB: begin
        rf_write = 1'b1;
        wb_sel   = 1'b1;
      end
      S_BRANCH: begin
        pc_load  = 1'b1;
        lr_write = link;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks state plus every strobe each cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, W_IR_valid;
  logic [31:0] IR;
  logic        write_ir, write_pc, pc_load, LA, LB, LC, LF;
  logic [3:0]  alu_op;
  logic        src_imm, mem_write, LD, rf_write, wb_sel, lr_write, illegal;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  // Strobe vector bit positions
  localparam logic [17:0] B_ILL = 18'h00001;
  localparam logic [17:0] B_LR  = 18'h00002;
  localparam logic [17:0] B_WBS = 18'h00004;
  localparam logic [17:0] B_RFW = 18'h00008;
  localparam logic [17:0] B_LD  = 18'h00010;
  localparam logic [17:0] B_MW  = 18'h00020;
  localparam logic [17:0] B_IMM = 18'h00040;
  localparam logic [17:0] B_LF  = 18'h00800;
  localparam logic [17:0] B_LC  = 18'h01000;
  localparam logic [17:0] B_LB  = 18'h02000;
  localparam logic [17:0] B_LA  = 18'h04000;
  localparam logic [17:0] B_PCL = 18'h08000;
  localparam logic [17:0] B_WPC = 18'h10000;
  localparam logic [17:0] B_WIR = 18'h20000;
  localparam logic [17:0] FETCH_ON = B_WIR | B_WPC;
  localparam logic [17:0] DEC      = B_LA | B_LB;

  function automatic logic [17:0] op(input logic [3:0] a);
    return {7'd0, a, 7'd0};
  endfunction

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .IR         (IR),
    .W_IR_valid (W_IR_valid),
    .write_ir   (write_ir),
    .write_pc   (write_pc),
    .pc_load    (pc_load),
    .LA         (LA),
    .LB         (LB),
    .LC         (LC),
    .LF         (LF),
    .alu_op     (alu_op),
    .src_imm    (src_imm),
    .mem_write  (mem_write),
    .LD         (LD),
    .rf_write   (rf_write),
    .wb_sel     (wb_sel),
    .lr_write   (lr_write),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] exp_st,
                              input logic [17:0] exp_sb);
    logic [17:0] obs;
    obs = {write_ir, write_pc, pc_load, LA, LB, LC, LF, alu_op,
           src_imm, mem_write, LD, rf_write, wb_sel, lr_write, illegal};
    checks++;
    assert (state === exp_st) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", tag, state, exp_st);
    end
    checks++;
    assert (obs === exp_sb) else begin
      errors++;
      $error("FAIL %s strobes: got %05h want %05h", tag, obs, exp_sb);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; W_IR_valid = 1'b0; IR = 32'h0;
    #2;
    expect_cycle("reset", 4'd0, 18'h0);
    step();
    expect_cycle("reset_held", 4'd0, 18'h0);
    @(negedge clk); rst = 1'b0; #1;
    expect_cycle("post_reset", 4'd0, FETCH_ON);

    // ADD R1,R2,R3: 0,1,2,4,0
    @(negedge clk); IR = 32'hE0821003; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    expect_cycle("add_dec", 4'd1, DEC);
    step(); expect_cycle("add_exec", 4'd2, B_LC | op(4'b0100));
    step(); expect_cycle("add_wb", 4'd4, B_RFW);
    step(); expect_cycle("add_done", 4'd0, FETCH_ON);

    // CMP R2,#5: 0,1,3,0
    IR = 32'hE3520005; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    expect_cycle("cmp_dec", 4'd1, DEC);
    step(); expect_cycle("cmp_exec", 4'd3, B_LC | B_LF | B_IMM | op(4'b1010));
    step(); expect_cycle("cmp_done", 4'd0, FETCH_ON);

    // Condition-failed fetches: stay in FETCH, PC keeps advancing
    for (int i = 0; i < 3; i++) begin
      step(); expect_cycle("skip", 4'd0, FETCH_ON);
    end

    // LDR R2,[R1,#4]: 0,1,5,6,7,0
    IR = 32'hE5912004; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    expect_cycle("ldr_dec", 4'd1, DEC);
    step(); expect_cycle("ldr_addr", 4'd5, B_IMM | B_LC | op(4'b0100));
    step(); expect_cycle("ldr_read", 4'd6, B_LD);
    step(); expect_cycle("ldr_wb", 4'd7, B_RFW | B_WBS);
    step(); expect_cycle("ldr_done", 4'd0, FETCH_ON);

    // STR with U=0 (SUB address): 0,1,5,8,0
    IR = 32'hE5012004; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    expect_cycle("strd_dec", 4'd1, DEC);
    step(); expect_cycle("strd_addr", 4'd5, B_IMM | B_LC | op(4'b0010));
    step(); expect_cycle("strd_write", 4'd8, B_MW);
    step(); expect_cycle("strd_done", 4'd0, FETCH_ON);

    // STR R2,[R1,#4], with run dropped mid-instruction: completes anyway
    IR = 32'hE5812004; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0; run = 1'b0;
    expect_cycle("str_dec", 4'd1, DEC);
    step(); expect_cycle("str_addr", 4'd5, B_IMM | B_LC | op(4'b0100));
    step(); expect_cycle("str_write", 4'd8, B_MW);
    step(); expect_cycle("str_done_norun", 4'd0, 18'h0);
    W_IR_valid = 1'b1;
    step(); expect_cycle("norun_hold", 4'd0, 18'h0);
    run = 1'b1; W_IR_valid = 1'b0; #1;
    expect_cycle("run_again", 4'd0, FETCH_ON);

    // BL: 0,1,9,0 with link
    IR = 32'hEB000002; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    expect_cycle("bl_dec", 4'd1, DEC);
    step(); expect_cycle("bl_br", 4'd9, B_PCL | B_LR);
    step(); expect_cycle("bl_done", 4'd0, FETCH_ON);

    // B: no link
    IR = 32'hEA000002; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    expect_cycle("b_dec", 4'd1, DEC);
    step(); expect_cycle("b_br", 4'd9, B_PCL);
    step(); expect_cycle("b_done", 4'd0, FETCH_ON);

    // Undefined class: illegal pulse in DECODE only
    IR = 32'hEC000000; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    expect_cycle("undef_dec", 4'd1, DEC | B_ILL);
    step(); expect_cycle("undef_done", 4'd0, FETCH_ON);

    // Reset during MEM_READ aborts immediately
    IR = 32'hE5912004; W_IR_valid = 1'b1;
    step(); W_IR_valid = 1'b0;
    step(); step();
    expect_cycle("abort_pre", 4'd6, B_LD);
    #2 rst = 1'b1; #1;
    expect_cycle("abort_rst", 4'd0, 18'h0);
    run = 1'b0; W_IR_valid = 1'b1;
    @(negedge clk); rst = 1'b0;
    step(); expect_cycle("abort_norun", 4'd0, 18'h0);
    step(); expect_cycle("abort_norun2", 4'd0, 18'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
